// File: rtl/frame_read_serializer.sv
// frame_read_serializer
//   Reads FRAME_WIDTH-bit words from a frame SRAM read port and streams them
//   out one byte at a time (byte 0 = bits [7:0] first) over valid/ready.
//
// Ports
//   clk_in     : sole clock, rising edge
//   reset      : synchronous, active-low
//   start      : one-cycle request, sampled only when idle
//   base_addr  : first word address (captured with start)
//   num_words  : number of words to read, 0..2^ADDR_WIDTH (captured with start)
//   abort      : ends the transfer early; done still pulses once
//   busy       : transfer in progress (low in the done cycle)
//   done       : one-cycle end-of-transfer pulse
//   csb/addr   : SRAM chip select (active-low) and read address
//   dout       : SRAM read data, valid RD_LAT cycles after the sampling edge
//   m_data/m_valid/m_ready : byte stream handshake
//
// Optional build macro FRAME_READ_PREFETCH_EN adds a staging register so the
// next word is fetched while the current one is still shifting out, removing
// the inter-word bubble. It requires FRAME_WIDTH/8 > RD_LAT.
module frame_read_serializer #(
  parameter int FRAME_WIDTH = 2048,
  parameter int ADDR_WIDTH  = 12,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    num_words,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   csb,
  output logic [ADDR_WIDTH-1:0]  addr,
  input  logic [FRAME_WIDTH-1:0] dout,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int NBYTES = FRAME_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAT_W  = 2;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, FIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;    // address of the word being shifted
  logic [ADDR_WIDTH:0]    rem_q, rem_d;      // words still to deliver, incl. current
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;  // byte 0 always sits in [7:0]
  logic                   xfer, last_xfer;

`ifdef FRAME_READ_PREFETCH_EN
  localparam logic [IDX_W-1:0] PF_IDX = IDX_W'(NBYTES - 1 - RD_LAT);
  logic [FRAME_WIDTH-1:0] stage_q, stage_d;
  logic                   pf_issued_q, pf_issued_d; // next-word read already issued
  logic                   pf_pend_q, pf_pend_d;     // that read has not returned yet
  logic [LAT_W-1:0]       pf_lat_q, pf_lat_d;
  logic                   pf_req, pf_arrive;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    busy    = (state_q == REQ) || (state_q == WAIT) || (state_q == SHIFT);
    done    = (state_q == FIN);
    csb     = (state_q != REQ);
    addr    = addr_q;
    m_valid = (state_q == SHIFT);
    m_data  = m_valid ? shift_q[7:0] : 8'h00;

    xfer      = m_valid && m_ready;
    last_xfer = xfer && (idx_q == LAST_IDX);

`ifdef FRAME_READ_PREFETCH_EN
    stage_d     = stage_q;
    pf_issued_d = pf_issued_q;
    pf_pend_d   = pf_pend_q;
    pf_lat_d    = pf_lat_q;
    // Issue early enough that data lands no later than the last-byte edge.
    pf_req    = (state_q == SHIFT) && !pf_issued_q && (rem_q > ONE_WORD) && (idx_q == PF_IDX);
    pf_arrive = pf_pend_q && (pf_lat_q == LAT_LAST);
    if (pf_req) begin
      csb         = 1'b0;
      addr        = addr_q + ADDR_WIDTH'(1);
      pf_issued_d = 1'b1;
      pf_pend_d   = 1'b1;
      pf_lat_d    = '0;
    end else if (pf_arrive) begin
      stage_d   = dout;
      pf_pend_d = 1'b0;
    end else if (pf_pend_q) begin
      pf_lat_d = pf_lat_q + LAT_W'(1);
    end
`endif

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          addr_d  = base_addr;
          rem_d   = num_words;
          state_d = (num_words == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        lat_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          shift_d = dout;
          idx_d   = '0;
          state_d = SHIFT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      SHIFT: begin
        if (xfer) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + IDX_W'(1);
          if (last_xfer) begin
            idx_d  = '0;
            addr_d = addr_q + ADDR_WIDTH'(1);  // wraps naturally at 2^ADDR_WIDTH
            rem_d  = rem_q - ONE_WORD;
            if (rem_q == ONE_WORD) begin
              state_d = FIN;
            end else begin
`ifdef FRAME_READ_PREFETCH_EN
              // Data may return on this very edge; bypass the staging register.
              shift_d     = pf_arrive ? dout : stage_q;
              pf_issued_d = 1'b0;
`else
              state_d = REQ;
`endif
            end
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort from an active state; FIN is left alone so done pulses only once.
    if (abort && busy) begin
      state_d = FIN;
    end

`ifdef FRAME_READ_PREFETCH_EN
    if (state_d != SHIFT) begin
      pf_issued_d = 1'b0;
      pf_pend_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef FRAME_READ_PREFETCH_EN
      stage_q     <= '0;
      pf_issued_q <= 1'b0;
      pf_pend_q   <= 1'b0;
      pf_lat_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef FRAME_READ_PREFETCH_EN
      stage_q     <= stage_d;
      pf_issued_q <= pf_issued_d;
      pf_pend_q   <= pf_pend_d;
      pf_lat_q    <= pf_lat_d;
`endif
    end
  end

endmodule
